assoc_cache: RTL

- K-way set-associative, write-allocate line store with registered single-cycle responses.
- Per-set true-LRU replacement using age counters.
- Reports victim evictions and supports a multi-cycle flush (invalidate-all) sequence.
- Sits between a requester and a backing store; the backing store consumes the eviction port.

---
 rtl/assoc_cache_pkg.sv | 23 ++
 rtl/assoc_cache_set.sv | 88 ++++++++
 rtl/assoc_cache.sv | 128 ++++++++++++
 3 files changed

// File: rtl/assoc_cache_pkg.sv
// Shared types and parameter-derived widths for the set-associative line store.
package assoc_cache_pkg;

  typedef enum logic {
    IDLE,
    FLUSH
  } fsm_state_e;

  function automatic int unsigned idx_width(input int unsigned set_count);
    return (set_count > 1) ? $clog2(set_count) : 1;
  endfunction

  function automatic int unsigned tag_width(input int unsigned addr_width,
                                            input int unsigned set_count);
    return addr_width - $clog2(set_count);
  endfunction

  // A direct-mapped build (K = 1) still carries a 1-bit age that stays at zero.
  function automatic int unsigned age_width(input int unsigned k);
    return (k > 1) ? $clog2(k) : 1;
  endfunction

endpackage

// File: rtl/assoc_cache_set.sv
// One set: K ways with tag compare, victim selection and age-counter LRU.
module cache_set
  import assoc_cache_pkg::*;
#(
  parameter int unsigned K          = 2,
  parameter int unsigned TAG_W      = 7,
  parameter int unsigned LINE_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  write,
  input  logic                  clr,
  input  logic [TAG_W-1:0]      tag,
  input  logic [LINE_WIDTH-1:0] wdata,
  output logic                  hit,
  output logic [LINE_WIDTH-1:0] rdata,
  output logic                  victim_valid,
  output logic [TAG_W-1:0]      victim_tag,
  output logic [LINE_WIDTH-1:0] victim_data
);

  localparam int unsigned AGE_W = age_width(K);
  typedef logic [AGE_W-1:0] way_t;

  logic [K-1:0]          valid;
  logic [TAG_W-1:0]      tags [K];
  logic [LINE_WIDTH-1:0] data [K];
  way_t                  age  [K];

  logic [K-1:0] match;
  way_t         hit_way;
  way_t         victim_way;
  way_t         touch_way;
  way_t         touch_age;

  always_comb begin
    match      = '0;
    hit_way    = '0;
    victim_way = '0;
    for (int unsigned w = 0; w < K; w++) begin
      match[w] = valid[w] && (tags[w] == tag);
      if (match[w]) hit_way = way_t'(w);
      if (age[w] == way_t'(K - 1)) victim_way = way_t'(w);
    end
    // Descending scan so the lowest-index invalid way overrides the LRU pick.
    for (int unsigned w = K; w > 0; w--) begin
      if (!valid[w-1]) victim_way = way_t'(w - 1);
    end
    hit          = |match;
    touch_way    = hit ? hit_way : victim_way;
    touch_age    = age[touch_way];
    rdata        = data[hit_way];
    victim_valid = valid[victim_way];
    victim_tag   = tags[victim_way];
    victim_data  = data[victim_way];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned w = 0; w < K; w++) begin
        valid[w] <= 1'b0;
        age[w]   <= way_t'(w);
        tags[w]  <= '0;
        data[w]  <= '0;
      end
    end else if (clr) begin
      for (int unsigned w = 0; w < K; w++) begin
        valid[w] <= 1'b0;
        age[w]   <= way_t'(w);
      end
    end else if (en && (hit || write)) begin
      if (write) begin
        valid[touch_way] <= 1'b1;
        tags[touch_way]  <= tag;
        data[touch_way]  <= wdata;
      end
      for (int unsigned w = 0; w < K; w++) begin
        if (way_t'(w) == touch_way) begin
          age[w] <= '0;
        end else if (age[w] < touch_age) begin
          age[w] <= age[w] + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/assoc_cache.sv
// K-way set-associative write-allocate line store: FSM, flush walk and registered responses.
module assoc_cache
  import assoc_cache_pkg::*;
#(
  parameter int unsigned SET_COUNT  = 2,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned LINE_WIDTH = 32,
  parameter int unsigned K          = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [LINE_WIDTH-1:0] req_wdata,
  input  logic                  flush,
  output logic                  flush_busy,
  output logic                  resp_valid,
  output logic                  resp_hit,
  output logic [LINE_WIDTH-1:0] resp_rdata,
  output logic                  evict_valid,
  output logic [ADDR_WIDTH-1:0] evict_addr,
  output logic [LINE_WIDTH-1:0] evict_data
);

  localparam int unsigned IDX_W = idx_width(SET_COUNT);
  localparam int unsigned TAG_W = tag_width(ADDR_WIDTH, SET_COUNT);

  fsm_state_e        state, state_next;
  logic [IDX_W-1:0]  flush_cnt, flush_cnt_next;
  logic              accept;
  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;

  logic [SET_COUNT-1:0]  set_hit;
  logic [SET_COUNT-1:0]  set_vvalid;
  logic [LINE_WIDTH-1:0] set_rdata [SET_COUNT];
  logic [LINE_WIDTH-1:0] set_vdata [SET_COUNT];
  logic [TAG_W-1:0]      set_vtag  [SET_COUNT];

  logic sel_hit;
  logic do_evict;

  assign idx = req_addr[IDX_W-1:0];
  assign tag = req_addr[ADDR_WIDTH-1:IDX_W];

  for (genvar s = 0; s < SET_COUNT; s++) begin : g_set
    cache_set #(
      .K          (K),
      .TAG_W      (TAG_W),
      .LINE_WIDTH (LINE_WIDTH)
    ) u_set (
      .clock        (clock),
      .reset        (reset),
      .en           (accept && (idx == IDX_W'(s))),
      .write        (req_write),
      .clr          ((state == FLUSH) && (flush_cnt == IDX_W'(s))),
      .tag          (tag),
      .wdata        (req_wdata),
      .hit          (set_hit[s]),
      .rdata        (set_rdata[s]),
      .victim_valid (set_vvalid[s]),
      .victim_tag   (set_vtag[s]),
      .victim_data  (set_vdata[s])
    );
  end

  always_comb begin
    state_next     = state;
    flush_cnt_next = flush_cnt;
    req_ready      = 1'b0;
    flush_busy     = 1'b0;
    case (state)
      IDLE: begin
        req_ready = !flush;
        if (flush) begin
          state_next     = FLUSH;
          flush_cnt_next = '0;
        end
      end
      FLUSH: begin
        flush_busy     = 1'b1;
        flush_cnt_next = flush_cnt + 1'b1;
        if (flush_cnt == IDX_W'(SET_COUNT - 1)) begin
          state_next     = IDLE;
          flush_cnt_next = '0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign accept   = req_valid && req_ready;
  assign sel_hit  = set_hit[idx];
  assign do_evict = accept && req_write && !sel_hit && set_vvalid[idx];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      flush_cnt <= '0;
    end else begin
      state     <= state_next;
      flush_cnt <= flush_cnt_next;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      resp_valid  <= 1'b0;
      resp_hit    <= 1'b0;
      resp_rdata  <= '0;
      evict_valid <= 1'b0;
      evict_addr  <= '0;
      evict_data  <= '0;
    end else begin
      resp_valid  <= accept;
      resp_hit    <= accept && sel_hit;
      resp_rdata  <= (accept && !req_write && sel_hit) ? set_rdata[idx] : '0;
      evict_valid <= do_evict;
      if (do_evict) begin
        evict_addr <= {set_vtag[idx], idx};
        evict_data <= set_vdata[idx];
      end
    end
  end

endmodule
